// File: rtl/cordic_job_dispatcher.sv
// Queues CORDIC requests and runs them one at a time on top_level_calc_cordic,
// returning each result with its caller tag, a timeout guard and opcode checking.
module cordic_job_dispatcher #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_op_i,
  input  logic [WIDTH-1:0] req_x_i,
  input  logic [WIDTH-1:0] req_y_i,
  input  logic [WIDTH-1:0] req_z_i,
  input  logic [TAG_W-1:0] req_tag_i,

  output logic             cordic_enable_o,
  output logic [3:0]       cordic_operation_o,
  output logic [WIDTH-1:0] cordic_x_o,
  output logic [WIDTH-1:0] cordic_y_o,
  output logic [WIDTH-1:0] cordic_z_o,
  input  logic [WIDTH-1:0] cordic_result_i,
  input  logic             cordic_done_i,

  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [1:0]       rsp_err_o,

  output logic             busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_DEFAULT = 4'b1111;
  localparam logic [3:0] OP_MAX     = 4'd9;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [3:0]       fifo_op_q  [DEPTH];
  logic [WIDTH-1:0] fifo_x_q   [DEPTH];
  logic [WIDTH-1:0] fifo_y_q   [DEPTH];
  logic [WIDTH-1:0] fifo_z_q   [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [3:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] drv_x_q, drv_y_q, drv_z_q;
  logic [TMO_W-1:0] tmo_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [1:0]       rsp_err_q;

  logic full, empty, push, pop;
  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_x, head_y, head_z;
  logic [TAG_W-1:0] head_tag;
  logic head_legal;
  logic timeout_hit;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Ready depends only on occupancy, so a full FIFO never accepts even while popping.
  assign push = req_valid_i && !full;
  assign pop  = (state_q == IDLE) && !empty;

  assign head_op    = fifo_op_q[rd_ptr_q];
  assign head_x     = fifo_x_q[rd_ptr_q];
  assign head_y     = fifo_y_q[rd_ptr_q];
  assign head_z     = fifo_z_q[rd_ptr_q];
  assign head_tag   = fifo_tag_q[rd_ptr_q];
  assign head_legal = (head_op <= OP_MAX);

  assign timeout_hit = (state_q == WAIT) && !cordic_done_i &&
                       (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_op_q[wr_ptr_q]  <= req_op_i;
      fifo_x_q[wr_ptr_q]   <= req_x_i;
      fifo_y_q[wr_ptr_q]   <= req_y_i;
      fifo_z_q[wr_ptr_q]   <= req_z_i;
      fifo_tag_q[wr_ptr_q] <= req_tag_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    cordic_enable_o    = 1'b0;
    cordic_operation_o = OP_DEFAULT;
    rsp_valid_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = head_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        cordic_enable_o    = 1'b1;
        cordic_operation_o = op_q;
        state_d            = WAIT;
      end
      WAIT: begin
        cordic_operation_o = op_q;
        if (cordic_done_i || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand drivers load only for legal jobs, so they keep the last issued values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q         <= '0;
      tag_q        <= '0;
      drv_x_q      <= '0;
      drv_y_q      <= '0;
      drv_z_q      <= '0;
      tmo_q        <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= ERR_OK;
    end else begin
      if (pop) begin
        op_q  <= head_op;
        tag_q <= head_tag;
        if (head_legal) begin
          drv_x_q <= head_x;
          drv_y_q <= head_y;
          drv_z_q <= head_z;
        end else begin
          rsp_result_q <= '0;
          rsp_err_q    <= ERR_ILLEGAL;
        end
      end
      if (state_q == ISSUE) begin
        tmo_q <= '0;
      end
      if (state_q == WAIT) begin
        if (cordic_done_i) begin
          rsp_result_q <= cordic_result_i;
          rsp_err_q    <= ERR_OK;
        end else if (timeout_hit) begin
          rsp_result_q <= '0;
          rsp_err_q    <= ERR_TIMEOUT;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
      end
    end
  end

  assign req_ready_o  = !full;
  assign cordic_x_o   = drv_x_q;
  assign cordic_y_o   = drv_y_q;
  assign cordic_z_o   = drv_z_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_tag_o    = tag_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_cordic_job_dispatcher.sv
// Directed bench for cordic_job_dispatcher; the test tasks play host and CORDIC stub
// by hand and compare each observation against hand-computed values.
module tb_cordic_job_dispatcher;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_x, req_y, req_z;
  logic [TAG_W-1:0] req_tag;
  logic             cordic_enable;
  logic [3:0]       cordic_operation;
  logic [WIDTH-1:0] cordic_x, cordic_y, cordic_z;
  logic [WIDTH-1:0] cordic_result;
  logic             cordic_done;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0]       rsp_err;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int enableCount = 0;

  cordic_job_dispatcher #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_x_i(req_x), .req_y_i(req_y), .req_z_i(req_z), .req_tag_i(req_tag),
    .cordic_enable_o(cordic_enable), .cordic_operation_o(cordic_operation),
    .cordic_x_o(cordic_x), .cordic_y_o(cordic_y), .cordic_z_o(cordic_z),
    .cordic_result_i(cordic_result), .cordic_done_i(cordic_done),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Counts enable pulses as seen at the edge that closes the ISSUE cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cordic_enable === 1'b1) enableCount = enableCount + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drivePush(input logic [3:0] op, input logic [WIDTH-1:0] x,
                           input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z,
                           input logic [TAG_W-1:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_x     = x;
    req_y     = y;
    req_z     = z;
    req_tag   = tag;
  endtask

  task automatic idleReq();
    req_valid = 1'b0;
  endtask

  task automatic waitEnable(input int baseEn, input string name);
    int n = 0;
    while (enableCount <= baseEn && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (enableCount <= baseEn) begin
      errors++;
      $display("[TB] FAIL %s: enable count %0d, required above %0d", name, enableCount, baseEn);
    end
  endtask

  task automatic serviceJob(input logic [TAG_W-1:0] expTag, input logic [WIDTH-1:0] result,
                            input int baseEn);
    waitEnable(baseEn, "service enable");
    cordic_done   = 1'b1;
    cordic_result = result;
    tick();
    cordic_done   = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL service valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_tag !== expTag) begin errors++; $display("[TB] FAIL service tag: got %0d want %0d", rsp_tag, expTag); end
    checks++; if (rsp_result !== result) begin errors++; $display("[TB] FAIL service result: got %h want %h", rsp_result, result); end
    checks++; if (rsp_err !== 2'b00) begin errors++; $display("[TB] FAIL service err: got %b want 00", rsp_err); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL service valid drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; req_z = '0; req_tag = '0;
    cordic_result = '0; cordic_done = 1'b0; rsp_ready = 1'b0;
    #1;
    checks++; if (cordic_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset enable: got %b want 0", cordic_enable); end
    checks++; if (cordic_operation !== 4'b1111) begin errors++; $display("[TB] FAIL reset op: got %h want f", cordic_operation); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset req_ready: got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    checks++; if ({cordic_x, rsp_result, rsp_tag, rsp_err} !== '0) begin errors++; $display("[TB] FAIL reset data: x=%h res=%h tag=%h err=%b want 0", cordic_x, rsp_result, rsp_tag, rsp_err); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_mult();
    int en0 = enableCount;
    drivePush(4'd4, 32'h0002_0000, 32'h0, 32'h0003_0000, 4'd5);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mult ready: got %b want 1", req_ready); end
    tick();
    idleReq();
    checks++; if (cordic_enable !== 1'b0) begin errors++; $display("[TB] FAIL mult enable N+1: got %b want 0", cordic_enable); end
    tick();
    checks++; if (cordic_enable !== 1'b1) begin errors++; $display("[TB] FAIL mult enable N+2: got %b want 1", cordic_enable); end
    checks++; if (cordic_operation !== 4'd4) begin errors++; $display("[TB] FAIL mult issue op: got %h want 4", cordic_operation); end
    checks++; if (cordic_x !== 32'h0002_0000 || cordic_z !== 32'h0003_0000) begin errors++; $display("[TB] FAIL mult issue operands: x=%h z=%h want 00020000 00030000", cordic_x, cordic_z); end
    for (int i = 0; i < 17; i++) begin
      tick();
      checks++;
      if (cordic_enable !== 1'b0 || cordic_operation !== 4'd4 || cordic_x !== 32'h0002_0000 ||
          cordic_y !== 32'h0 || cordic_z !== 32'h0003_0000) begin
        errors++;
        $display("[TB] FAIL mult wait stable: en=%b op=%h x=%h y=%h z=%h want 0 4 00020000 0 00030000",
                 cordic_enable, cordic_operation, cordic_x, cordic_y, cordic_z);
      end
    end
    cordic_done = 1'b1;
    cordic_result = 32'h0006_0000;
    tick();
    cordic_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL mult rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_result !== 32'h0006_0000) begin errors++; $display("[TB] FAIL mult result: got %h want 00060000", rsp_result); end
    checks++; if (rsp_tag !== 4'd5) begin errors++; $display("[TB] FAIL mult tag: got %0d want 5", rsp_tag); end
    checks++; if (rsp_err !== 2'b00) begin errors++; $display("[TB] FAIL mult err: got %b want 00", rsp_err); end
    checks++; if (enableCount !== en0 + 1) begin errors++; $display("[TB] FAIL mult pulses: got %0d want %0d", enableCount, en0 + 1); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mult rsp drop: got %b want 0", rsp_valid); end
    checks++; if (cordic_operation !== 4'b1111) begin errors++; $display("[TB] FAIL mult idle op: got %h want f", cordic_operation); end
    checks++; if (cordic_x !== 32'h0002_0000) begin errors++; $display("[TB] FAIL mult x kept: got %h want 00020000", cordic_x); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mult busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int en0 = enableCount;
    int late = 0;
    rsp_ready = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      drivePush(4'd0, WIDTH'(t) << 16, 32'h0, WIDTH'(t), TAG_W'(t));
      checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b ready before push %0d: got %b want 1", t, req_ready); end
      tick();
    end
    drivePush(4'd0, 32'h0, 32'h0, 32'h0, 4'd6);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b full ready: got %b want 0", req_ready); end
    tick();
    idleReq();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b busy: got %b want 1", busy); end
    for (int t = 1; t <= 5; t++) begin
      serviceJob(TAG_W'(t), WIDTH'(t * 32'h111), en0 + t - 1);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cordic_enable === 1'b1 || rsp_valid === 1'b1) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("[TB] FAIL b2b rejected push leaked: activity %0d want 0", late); end
    checks++; if (enableCount !== en0 + 5) begin errors++; $display("[TB] FAIL b2b pulses: got %0d want %0d", enableCount, en0 + 5); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b drained: busy=%b ready=%b want 0 1", busy, req_ready); end
  endtask

  task automatic test_illegal();
    int en0 = enableCount;
    int n = 0;
    drivePush(4'b1111, 32'h1234, 32'h5678, 32'h9abc, 4'd7);
    tick();
    idleReq();
    while (rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL illegal rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (n !== 1) begin errors++; $display("[TB] FAIL illegal latency: got %0d extra cycles want 1", n); end
    checks++; if (rsp_err !== 2'b01) begin errors++; $display("[TB] FAIL illegal err: got %b want 01", rsp_err); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("[TB] FAIL illegal result: got %h want 0", rsp_result); end
    checks++; if (rsp_tag !== 4'd7) begin errors++; $display("[TB] FAIL illegal tag: got %0d want 7", rsp_tag); end
    checks++; if (enableCount !== en0 || cordic_operation !== 4'b1111) begin errors++; $display("[TB] FAIL illegal no issue: pulses=%0d op=%h want %0d f", enableCount, cordic_operation, en0); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL illegal rsp drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_timeout();
    int en0 = enableCount;
    int n = 0;
    int cycE;
    drivePush(4'd1, 32'h1000, 32'h2000, 32'h3000, 4'd9);
    tick();
    idleReq();
    while (cordic_enable !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++; if (cordic_enable !== 1'b1) begin errors++; $display("[TB] FAIL timeout issue: enable %b want 1", cordic_enable); end
    tick();
    cycE = cyc;
    drivePush(4'd3, 32'h4000, 32'h5000, 32'h6000, 4'd10);
    tick();
    idleReq();
    while (cyc < cycE + TIMEOUT - 1) tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout early: rsp_valid %b want 0 at WAIT+63", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL timeout valid: got %b want 1 at WAIT+64", rsp_valid); end
    checks++; if (rsp_err !== 2'b10) begin errors++; $display("[TB] FAIL timeout err: got %b want 10", rsp_err); end
    checks++; if (rsp_result !== 32'h0 || rsp_tag !== 4'd9) begin errors++; $display("[TB] FAIL timeout payload: res=%h tag=%0d want 0 9", rsp_result, rsp_tag); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    serviceJob(4'd10, 32'h0000_abcd, en0 + 1);
    checks++; if (cordic_x !== 32'h4000 || cordic_z !== 32'h6000) begin errors++; $display("[TB] FAIL timeout next operands: x=%h z=%h want 4000 6000", cordic_x, cordic_z); end
  endtask

  task automatic test_reset_mid();
    int en0 = enableCount;
    int seen = 0;
    drivePush(4'd0, 32'h7000, 32'h0, 32'h0, 4'd1);
    tick();
    idleReq();
    waitEnable(en0, "midreset issue");
    drivePush(4'd1, 32'h8000, 32'h0, 32'h0, 4'd2);
    tick();
    drivePush(4'd2, 32'h9000, 32'h0, 32'h0, 4'd3);
    tick();
    idleReq();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cordic_enable !== 1'b0 || cordic_operation !== 4'b1111) begin errors++; $display("[TB] FAIL midreset cordic: en=%b op=%h want 0 f", cordic_enable, cordic_operation); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset status: busy=%b ready=%b valid=%b want 0 1 0", busy, req_ready, rsp_valid); end
    checks++; if (cordic_x !== 32'h0 || rsp_tag !== '0) begin errors++; $display("[TB] FAIL midreset data: x=%h tag=%0d want 0 0", cordic_x, rsp_tag); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midreset ghost response: %0d cycles valid want 0", seen); end
    checks++; if (enableCount !== en0 + 1) begin errors++; $display("[TB] FAIL midreset pulses: got %0d want %0d", enableCount, en0 + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset busy after: got %b want 0", busy); end
  endtask

  task automatic test_resp_hold();
    int en0 = enableCount;
    drivePush(4'd4, 32'h0001_0000, 32'h0, 32'h0002_0000, 4'd3);
    tick();
    idleReq();
    waitEnable(en0, "hold issue");
    cordic_done = 1'b1;
    cordic_result = 32'h1234_5678;
    tick();
    cordic_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cordic_done = (i == 4);
      cordic_result = (i == 4) ? 32'hdead_beef : 32'h1234_5678;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h1234_5678 || rsp_tag !== 4'd3 || rsp_err !== 2'b00) begin
        errors++;
        $display("[TB] FAIL hold cycle %0d: valid=%b res=%h tag=%0d err=%b want 1 12345678 3 00",
                 i, rsp_valid, rsp_result, rsp_tag, rsp_err);
      end
    end
    cordic_done = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold rsp drop: got %b want 0", rsp_valid); end
    tick();
    checks++; if (busy !== 1'b0 || enableCount !== en0 + 1) begin errors++; $display("[TB] FAIL hold idle: busy=%b pulses=%0d want 0 %0d", busy, enableCount, en0 + 1); end
  endtask

  initial begin
    test_reset();
    test_single_mult();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_resp_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
